// File: rtl/pipe_ctrl_n.sv
// Pipeline stall/flush controller for an N-slot pipeline.
// Builds the stall vector, sequences exception flushes and PC redirects.
module pipe_ctrl_n #(
    parameter int               NSTAGE        = 6,
    parameter int               WIDTH         = 32,
    parameter logic [WIDTH-1:0] EXC_BASE      = WIDTH'(32'h00008000),
    parameter int               FLUSH_CYCLES  = 1,
    parameter int               STALL_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic [WIDTH-1:0]  excepttype_i,
    input  logic [WIDTH-1:0]  cp0_epc_i,
    output logic [NSTAGE-1:0] stall,
    output logic              flush,
    output logic [WIDTH-1:0]  new_pc,
    output logic              new_pc_valid,
    output logic [31:0]       stall_cnt,
    output logic              stall_timeout
);

    localparam int RW = (STALL_TIMEOUT < 1) ? 1 : $clog2(STALL_TIMEOUT + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STALL_TIMEOUT);
    localparam logic [3:0] FC_LOAD = 4'(FLUSH_CYCLES - 1);

    localparam logic [WIDTH-1:0] EXC_INT  = WIDTH'(32'h0000000F);
    localparam logic [WIDTH-1:0] EXC_ERET = WIDTH'(32'h0000000E);
    localparam logic [WIDTH-1:0] VEC_INT  = EXC_BASE + WIDTH'(32'h20);
    localparam logic [WIDTH-1:0] VEC_GEN  = EXC_BASE + WIDTH'(32'h40);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       fcnt_q;
    logic [3:0]       fcnt_d;
    logic             take;
    logic             exc_nz;
    logic             is_int;
    logic             is_eret;
    logic             is_gen;
    logic             vec_hit;
    logic [WIDTH-1:0] vec;
    logic [NSTAGE-1:0] therm;
    logic             acc;
    logic             stall_nz;
    logic [RW-1:0]    run_q;
    logic [RW-1:0]    run_d;
    logic             to_set;
    logic [WIDTH-1:0] new_pc_q;
    logic             new_pc_valid_q;
    logic [31:0]      stall_cnt_q;
    logic             stall_timeout_q;

    assign exc_nz = |excepttype_i;

    // Thermometer below the highest requesting interior slot
    always_comb begin
        therm = '0;
        acc   = 1'b0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (i >= 1 && i <= NSTAGE - 2 && stallreq_i[i]) begin
                acc = 1'b1;
            end
            therm[i] = acc;
        end
    end

    assign stall    = (rst || state_q == FLUSH || exc_nz) ? '0 : therm;
    assign stall_nz = |stall;

    always_comb begin
        is_int  = excepttype_i == EXC_INT;
        is_eret = excepttype_i == EXC_ERET;
        is_gen  = 1'b0;
        unique case (excepttype_i)
            WIDTH'(1), WIDTH'(2), WIDTH'(3), WIDTH'(4), WIDTH'(5),
            WIDTH'(8), WIDTH'(10), WIDTH'(11), WIDTH'(23): is_gen = 1'b1;
            default: is_gen = 1'b0;
        endcase
    end

    always_comb begin
        vec     = new_pc_q;
        vec_hit = 1'b1;
        unique case (1'b1)
            is_int:  vec = VEC_INT;
            is_eret: vec = cp0_epc_i;
            is_gen:  vec = VEC_GEN;
            default: vec_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        take    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (exc_nz) begin
                    state_d = FLUSH;
                    fcnt_d  = FC_LOAD;
                    take    = 1'b1;
                end
            end
            FLUSH: begin
                if (fcnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_pc_q       <= '0;
            new_pc_valid_q <= 1'b0;
        end else begin
            new_pc_valid_q <= take && vec_hit;
            if (take && vec_hit) begin
                new_pc_q <= vec;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_nz && stall_cnt_q != 32'hFFFFFFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    // Run length saturates at the threshold so the flag test stays simple
    always_comb begin
        run_d = '0;
        if (stall_nz) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
        end
        to_set = (STALL_TIMEOUT != 0) && stall_nz && (run_d == RUN_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q           <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            run_q <= run_d;
            if (take) begin
                stall_timeout_q <= 1'b0;
            end else if (to_set) begin
                stall_timeout_q <= 1'b1;
            end
        end
    end

    assign flush         = state_q == FLUSH;
    assign new_pc        = new_pc_q;
    assign new_pc_valid  = new_pc_valid_q;
    assign stall_cnt     = stall_cnt_q;
    assign stall_timeout = stall_timeout_q;

endmodule
